// File: rtl/imem_boot_ctrl.sv
// Boot/load controller: holds the core halted, streams host bytes into the instruction
// store as little-endian words, then releases the core and passes fetches through.
module imem_boot_ctrl #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [ADDRESS_WIDTH-2:0]   load_len,
   input  logic                       byte_valid,
   input  logic [7:0]                 byte_data,
   output logic                       byte_ready,
   input  logic [ADDRESS_WIDTH-1:0]   cpu_addr,
   output logic [DATA_WIDTH-1:0]      cpu_instr,
   output logic                       cpu_en,
   output logic [ADDRESS_WIDTH-1:0]   mem_raddr,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   output logic                       mem_we,
   output logic [ADDRESS_WIDTH-3:0]   mem_waddr,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int unsigned LenW = ADDRESS_WIDTH - 1;
   localparam logic [LenW-1:0] MaxWords = LenW'(1) << (ADDRESS_WIDTH - 2);
   localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {StHalt, StLoad, StRun} state_e;

   state_e                  state_q, state_d;
   logic [LenW-1:0]         len_q, len_d;
   logic [LenW-1:0]         wcnt_q, wcnt_d;
   logic [1:0]              bcnt_q, bcnt_d;
   logic [23:0]             asm_q, asm_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic                    start_acc;
   logic                    accept;
   logic                    last_word;
   logic [LenW-1:0]         len_clamped;

   // done_q in LOAD marks the final-write cycle; no further bytes are taken then.
   assign byte_ready  = (state_q == StLoad) && !done_q;
   assign accept      = byte_valid && byte_ready;
   assign start_acc   = start && (state_q != StLoad);
   assign last_word   = (wcnt_q == len_q - LenW'(1));
   assign len_clamped = (load_len > MaxWords) ? MaxWords : load_len;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      bcnt_d  = bcnt_q;
      asm_d   = asm_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      err_d   = err_q;

      if (we_q) begin
         wcnt_d = wcnt_q + LenW'(1);
      end

      unique case (state_q)
         StHalt: ;
         StLoad: begin
            if (start) begin
               err_d = 1'b1;
            end
            if (accept) begin
               bcnt_d = bcnt_q + 2'd1;
               unique case (bcnt_q)
                  2'd0: asm_d[7:0]   = byte_data;
                  2'd1: asm_d[15:8]  = byte_data;
                  2'd2: asm_d[23:16] = byte_data;
                  2'd3: begin
                     we_d    = 1'b1;
                     wdata_d = DATA_WIDTH'({byte_data, asm_q});
                     done_d  = last_word;
                  end
               endcase
            end
            if (done_q) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (cpu_addr[1:0] != 2'b00) begin
               err_d = 1'b1;
            end
         end
         default: state_d = StHalt;
      endcase

      // An accepted start overrides any error raised in the same cycle.
      if (start_acc) begin
         len_d   = len_clamped;
         err_d   = 1'b0;
         bcnt_d  = 2'd0;
         wcnt_d  = '0;
         done_d  = (len_clamped == '0);
         state_d = (len_clamped == '0) ? StRun : StLoad;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StHalt;
         len_q   <= '0;
         wcnt_q  <= '0;
         bcnt_q  <= 2'd0;
         asm_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cpu_en    = (state_q == StRun);
   assign busy      = (state_q == StLoad);
   assign mem_we    = we_q;
   assign mem_waddr = wcnt_q[ADDRESS_WIDTH-3:0];
   assign mem_wdata = wdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_raddr = cpu_addr;
   assign cpu_instr = (cpu_en && (cpu_addr[1:0] == 2'b00)) ? mem_rdata : Nop;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a small instruction memory (16 words).
module tb_imem_boot_ctrl;

   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-2:0] load_len;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_instr;
   logic          cpu_en;
   logic [AW-1:0] mem_raddr;
   logic [31:0]   mem_rdata;
   logic          mem_we;
   logic [AW-3:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic          busy;
   logic          done;
   logic          err;

   imem_boot_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_en(cpu_en),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   logic [31:0] tb_mem [16];
   int          we_cnt = 0;
   int          done_cnt = 0;
   int          last_waddr = -1;
   int          errors = 0;
   int          checks = 0;

   assign mem_rdata = tb_mem[mem_raddr[AW-1:2]];

   // Registered outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (mem_we) begin
         tb_mem[mem_waddr] = mem_wdata;
         we_cnt++;
         last_waddr = int'(mem_waddr);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a byte and returns #1 after the edge that accepted it.
   task automatic send_byte(input logic [7:0] d);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = d;
      while (!byte_ready && n < 20) begin
         step();
         n++;
      end
      check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
      step();
   endtask

   task automatic do_start(input logic [AW-2:0] len);
      start    = 1'b1;
      load_len = len;
      step();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int base);
      int n = 0;
      while (done_cnt == base && n < 40) begin
         step();
         n++;
      end
      check("done_wait", done_cnt - base, 1);
   endtask

   logic [7:0] prog [8];
   int we_base;
   int done_base;

   initial begin
      prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      for (int i = 0; i < 16; i++) tb_mem[i] = 32'hdead_0000 + i;
      rst_n = 1'b0; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
      cpu_addr = '0;
      repeat (3) step();

      // Reset state
      check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
      check("rst_cpu_instr", cpu_instr, 32'h0000_0013);
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_waddr", {28'd0, mem_waddr}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
      rst_n = 1'b1;
      repeat (2) step();
      check("halt_no_start", {30'd0, cpu_en, busy}, 32'd0);

      // Back-to-back load of two words
      we_base = we_cnt;
      do_start(2);
      check("load_busy", {30'd0, busy, byte_ready}, 32'd3);
      for (int i = 0; i < 8; i++) begin
         send_byte(prog[i]);
         if (i == 2) check("no_early_we", {31'd0, mem_we}, 32'd0);
         if (i == 3) begin
            check("w0_we", {31'd0, mem_we}, 32'd1);
            check("w0_addr", {28'd0, mem_waddr}, 32'd0);
            check("w0_data", mem_wdata, 32'h0050_0513);
            check("w0_no_done", {31'd0, done}, 32'd0);
         end
      end
      byte_valid = 1'b0;
      check("w1_we", {31'd0, mem_we}, 32'd1);
      check("w1_addr", {28'd0, mem_waddr}, 32'd1);
      check("w1_data", mem_wdata, 32'h0010_0593);
      check("w1_done", {31'd0, done}, 32'd1);
      check("w1_ready_low", {31'd0, byte_ready}, 32'd0);
      check("w1_cpu_en_low", {31'd0, cpu_en}, 32'd0);
      step();
      check("run_cpu_en", {31'd0, cpu_en}, 32'd1);
      check("run_done_low", {30'd0, done, mem_we}, 32'd0);
      check("b2b_we_count", we_cnt - we_base, 2);
      cpu_addr = 6'd4;
      #1 check("fetch4", cpu_instr, 32'h0010_0593);
      check("raddr", {26'd0, mem_raddr}, 32'd4);
      cpu_addr = 6'd0;
      #1 check("fetch0", cpu_instr, 32'h0050_0513);

      // Gapped reload from RUN with a mid-load start pulse
      tb_mem[0] = '0; tb_mem[1] = '0;
      we_base = we_cnt; done_base = done_cnt;
      do_start(2);
      check("reload_halts_cpu", {30'd0, cpu_en, busy}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(0, 3)) step();
         send_byte(prog[i]);
         if (i == 1) begin
            byte_valid = 1'b0;
            start = 1'b1;
            load_len = 5'd1;
            step();
            start = 1'b0;
            check("mid_start_err", {30'd0, err, busy}, 32'd3);
         end
      end
      byte_valid = 1'b0;
      wait_done(done_base);
      step();
      check("gap_we_count", we_cnt - we_base, 2);
      check("gap_w0", tb_mem[0], 32'h0050_0513);
      check("gap_w1", tb_mem[1], 32'h0010_0593);
      check("gap_err_sticky", {30'd0, err, cpu_en}, 32'd3);

      // Zero-length reload clears err; then a misaligned fetch sets it
      we_base = we_cnt;
      do_start(0);
      check("len0_done", {29'd0, done, cpu_en, err}, 32'd6);
      check("len0_no_we", {31'd0, mem_we}, 32'd0);
      step();
      check("len0_done_pulse", {30'd0, done, cpu_en}, 32'd1);
      check("len0_we_count", we_cnt - we_base, 0);
      cpu_addr = 6'd2;
      #1 check("misaligned_nop", cpu_instr, 32'h0000_0013);
      step();
      check("misaligned_err", {31'd0, err}, 32'd1);
      cpu_addr = 6'd0;

      // Reset after 6 of 8 bytes
      tb_mem[0] = '0; tb_mem[1] = 32'h5555_aaaa;
      we_base = we_cnt;
      do_start(2);
      for (int i = 0; i < 6; i++) send_byte(prog[i]);
      byte_valid = 1'b0;
      rst_n = 1'b0;
      #1 check("midrst_outputs", {28'd0, busy, cpu_en, mem_we, byte_ready}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("midrst_we_count", we_cnt - we_base, 1);
      check("midrst_w1_untouched", tb_mem[1], 32'h5555_aaaa);
      we_base = we_cnt; done_base = done_cnt;
      do_start(1);
      send_byte(8'h37); send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
      byte_valid = 1'b0;
      check("one_word_done", {31'd0, done}, 32'd1);
      check("one_word_addr", {28'd0, mem_waddr}, 32'd0);
      step();
      check("one_word_mem", tb_mem[0], 32'h0000_1237);
      check("one_word_counts", {we_cnt - we_base, done_cnt - done_base}, {32'd1, 32'd1});

      // Oversized length clamps to 16 words
      we_base = we_cnt; done_base = done_cnt;
      do_start(5'd20);
      for (int i = 0; i < 64; i++) send_byte(8'(i));
      byte_valid = 1'b0;
      check("clamp_done", {31'd0, done}, 32'd1);
      step();
      check("clamp_we_count", we_cnt - we_base, 16);
      check("clamp_last_addr", last_waddr, 15);
      check("clamp_last_word", tb_mem[15], 32'h3f3e_3d3c);
      check("clamp_run", {30'd0, cpu_en, byte_ready}, 32'd2);
      cpu_addr = 6'd60;
      #1 check("clamp_fetch", cpu_instr, 32'h3f3e_3d3c);
      repeat (3) step();
      check("clamp_no_extra_we", we_cnt - we_base, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
